// File: rtl/tm_pkg.sv
// Shared TM framing constants, FSM encoding and the CCSDS pseudo-randomizer step.
// The randomizer is Fibonacci form, h(x)=x^8+x^7+x^5+x^3+1, taps on state bits 7,5,3,0.
package tm_pkg;

  typedef logic [7:0] sym_t;

  localparam logic [31:0] ASM_DEFAULT = 32'h1ACFFC1D;
  localparam logic [7:0]  RAND_TAPS   = 8'hA9;
  localparam logic [7:0]  RAND_SEED   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STRT,
    ST_ASMB,
    ST_DATA
  } fsm_t;

  // Returns {randomizer byte, next state}; the first bit shifted out lands in the byte MSB.
  function automatic logic [15:0] lfsr_byte_next(input logic [7:0] st);
    logic [7:0] s;
    logic [7:0] b;
    s = st;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], s[0]};
      s = {^(s & RAND_TAPS), s[7:1]};
    end
    return {b, s};
  endfunction

endpackage

// File: rtl/tm_cadu_framer_if.sv
// Encoder-facing handshake and CADU byte stream of the framer.
// master = framer side, slave = encoder/serializer side.
interface tm_cadu_framer_if;
  import tm_pkg::*;

  logic encRfs;
  logic encStart;
  sym_t rsIn;
  logic rsRdy;
  sym_t outDat;
  logic outValid;
  logic outSof;
  logic outEof;

  modport master (
    input  encRfs, rsIn, rsRdy,
    output encStart, outDat, outValid, outSof, outEof
  );

  modport slave (
    output encRfs, rsIn, rsRdy,
    input  encStart, outDat, outValid, outSof, outEof
  );
endinterface

// File: rtl/tm_cadu_fifo.sv
// Show-ahead synchronous FIFO, depth 2**FIFO_AW; dout is valid whenever empty=0.
// Push when full is ignored unless a pop happens in the same cycle.
module tm_cadu_fifo #(
  parameter int FIFO_AW = 3,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          nGrst,
  input  logic          rst,
  input  logic          clkEn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clkEn) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clkEn && !rst && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tm_cadu_framer.sv
// CADU framer: starts the RS encoder, then emits ASM + NN randomized codeword bytes.
// One registered output stage; FIFO underrun leaves holes, FIFO overflow sets sticky ovfErr.
module tm_cadu_framer
  import tm_pkg::*;
#(
  parameter int          NN      = 255,
  parameter logic [31:0] ASM     = ASM_DEFAULT,
  parameter bit          RAND_EN = 1'b1,
  parameter int          FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             nGrst,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             go,
  output logic             busy,
  output logic             ovfErr,
  tm_cadu_framer_if.master bus
);

  fsm_t        st_q, st_d;
  logic [1:0]  asm_cnt_q, asm_cnt_d;
  logic [7:0]  dat_cnt_q, dat_cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] rnd;
  logic [31:0] asm_sh;

  sym_t        out_dat_q, out_dat_d;
  logic        out_vld_q, out_vld_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        ovf_err_q;

  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  sym_t        fifo_dout;

  tm_cadu_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (8)
  ) u_fifo (
    .clk   (clk),
    .nGrst (nGrst),
    .rst   (rst),
    .clkEn (clkEn),
    .push  (bus.rsRdy),
    .pop   (fifo_pop),
    .din   (bus.rsIn),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rnd    = lfsr_byte_next(lfsr_q);
  // asm_cnt 0..3 selects bytes [31:24]..[7:0]
  assign asm_sh = ASM >> {~asm_cnt_q, 3'b000};

  always_comb begin
    st_d      = st_q;
    asm_cnt_d = asm_cnt_q;
    dat_cnt_d = dat_cnt_q;
    lfsr_d    = lfsr_q;
    out_dat_d = '0;
    out_vld_d = 1'b0;
    out_sof_d = 1'b0;
    out_eof_d = 1'b0;
    fifo_pop  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (go && bus.encRfs) st_d = ST_STRT;
      end
      ST_STRT: begin
        lfsr_d    = RAND_SEED;
        asm_cnt_d = '0;
        dat_cnt_d = '0;
        st_d      = ST_ASMB;
      end
      ST_ASMB: begin
        out_vld_d = 1'b1;
        out_sof_d = (asm_cnt_q == 2'd0);
        out_dat_d = asm_sh[7:0];
        asm_cnt_d = asm_cnt_q + 2'd1;
        if (asm_cnt_q == 2'd3) st_d = ST_DATA;
      end
      ST_DATA: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          out_vld_d = 1'b1;
          out_dat_d = RAND_EN ? (fifo_dout ^ rnd[15:8]) : fifo_dout;
          lfsr_d    = rnd[7:0];
          dat_cnt_d = dat_cnt_q + 8'd1;
          if (dat_cnt_q == 8'(NN - 1)) begin
            out_eof_d = 1'b1;
            st_d      = ST_IDLE;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      st_q      <= ST_IDLE;
      asm_cnt_q <= '0;
      dat_cnt_q <= '0;
      lfsr_q    <= RAND_SEED;
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
      out_sof_q <= 1'b0;
      out_eof_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else if (clkEn) begin
      if (rst) begin
        st_q      <= ST_IDLE;
        asm_cnt_q <= '0;
        dat_cnt_q <= '0;
        lfsr_q    <= RAND_SEED;
        out_dat_q <= '0;
        out_vld_q <= 1'b0;
        out_sof_q <= 1'b0;
        out_eof_q <= 1'b0;
        ovf_err_q <= 1'b0;
      end else begin
        st_q      <= st_d;
        asm_cnt_q <= asm_cnt_d;
        dat_cnt_q <= dat_cnt_d;
        lfsr_q    <= lfsr_d;
        out_dat_q <= out_dat_d;
        out_vld_q <= out_vld_d;
        out_sof_q <= out_sof_d;
        out_eof_q <= out_eof_d;
        // a simultaneous pop frees a slot, so full+push+pop is not an overflow
        if (bus.rsRdy && fifo_full && !fifo_pop) ovf_err_q <= 1'b1;
      end
    end
  end

  assign bus.encStart = (st_q == ST_STRT);
  assign bus.outDat   = out_dat_q;
  assign bus.outValid = out_vld_q;
  assign bus.outSof   = out_sof_q;
  assign bus.outEof   = out_eof_q;
  assign busy         = (st_q != ST_IDLE);
  assign ovfErr       = ovf_err_q;

endmodule

// File: tb/tb_tm_cadu_framer.sv
// Scoreboard bench: two framers (randomized and raw) share one encoder model; monitors check each output byte.
module tb_tm_cadu_framer;
  import tm_pkg::*;

  localparam int NN = 16;

  typedef struct packed {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
  } exp_t;

  typedef struct packed {
    logic [15:0][7:0] d;
    int               stall_at;
    int               stall_len;
  } cw_t;

  logic clk = 1'b0;
  logic nGrst = 1'b1;
  logic rst = 1'b0;
  logic clkEn = 1'b1;
  logic go = 1'b0;
  logic enc_rfs = 1'b1;
  logic rs_rdy = 1'b0;
  logic [7:0] rs_in = 8'h00;
  logic busy, ovf_err, busy_raw, ovf_err_raw;

  tm_cadu_framer_if bus ();
  tm_cadu_framer_if bus_raw ();

  assign bus.encRfs     = enc_rfs;
  assign bus.rsIn       = rs_in;
  assign bus.rsRdy      = rs_rdy;
  assign bus_raw.encRfs = enc_rfs;
  assign bus_raw.rsIn   = rs_in;
  assign bus_raw.rsRdy  = rs_rdy;

  tm_cadu_framer #(.NN(NN), .ASM(32'h1ACFFC1D), .RAND_EN(1'b1), .FIFO_AW(3)) u_dut (
    .clk(clk), .nGrst(nGrst), .rst(rst), .clkEn(clkEn), .go(go),
    .busy(busy), .ovfErr(ovf_err), .bus(bus)
  );

  tm_cadu_framer #(.NN(NN), .ASM(32'h1ACFFC1D), .RAND_EN(1'b0), .FIFO_AW(3)) u_raw (
    .clk(clk), .nGrst(nGrst), .rst(rst), .clkEn(clkEn), .go(go),
    .busy(busy_raw), .ovfErr(ovf_err_raw), .bus(bus_raw)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int n_seen = 0;
  int n_raw_vld = 0;
  int n_start = 0;
  int ovf_req = 0;
  int ovf_req_n = 0;
  int ovf_srv = 0;
  bit abort = 1'b0;
  exp_t q_rand[$];
  exp_t q_raw[$];
  cw_t cw_q[$];
  cw_t enc_cw;
  cw_t cw;
  cw_t cw2;
  logic [7:0] rand_tab [16];
  logic [31:0] asm_w;
  int base, v0, t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (bus.outValid === 1'b1) begin
      n_seen++;
      if (q_rand.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rand unexpected byte: got %02h, required no output", bus.outDat);
      end else begin
        chk($sformatf("rand out %0d {dat,sof,eof}", n_seen),
            32'({bus.outDat, bus.outSof, bus.outEof}), 32'(q_rand.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_raw.outValid === 1'b1) begin
      n_raw_vld++;
      if (q_raw.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL raw unexpected byte: got %02h, required no output", bus_raw.outDat);
      end else begin
        chk($sformatf("raw out %0d {dat,sof,eof}", n_raw_vld),
            32'({bus_raw.outDat, bus_raw.outSof, bus_raw.outEof}), 32'(q_raw.pop_front()));
      end
    end
  end

  // Encoder model: answers encStart with a queued codeword, or issues free-running pushes on request
  initial begin : enc_model
    forever begin
      @(negedge clk);
      if (ovf_req != ovf_srv) begin
        ovf_srv = ovf_req;
        @(posedge clk);
        #1;
        for (int i = 0; i < ovf_req_n; i++) begin
          rs_in = 8'(i);
          rs_rdy = 1'b1;
          @(posedge clk);
          #1;
        end
        rs_rdy = 1'b0;
      end else if (bus.encStart === 1'b1) begin
        n_start++;
        if (cw_q.size() != 0) begin
          enc_cw = cw_q.pop_front();
          enc_rfs = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          for (int i = 0; i < NN && !abort; i++) begin
            if (i == enc_cw.stall_at) begin
              rs_rdy = 1'b0;
              repeat (enc_cw.stall_len) @(posedge clk);
              #1;
            end
            rs_in = enc_cw.d[i];
            rs_rdy = 1'b1;
            @(posedge clk);
            #1;
          end
          rs_rdy = 1'b0;
          enc_rfs = 1'b1;
        end
      end
    end
  end

  task automatic expect_frame(input cw_t c);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = asm_w[31-8*i -: 8];
      q_rand.push_back(exp_t'({b, (i == 0), 1'b0}));
      q_raw.push_back(exp_t'({b, (i == 0), 1'b0}));
    end
    for (int i = 0; i < NN; i++) begin
      q_rand.push_back(exp_t'({c.d[i] ^ rand_tab[i], 1'b0, (i == NN-1)}));
      q_raw.push_back(exp_t'({c.d[i], 1'b0, (i == NN-1)}));
    end
  endtask

  task automatic run_frames(input int nframes, input string name);
    int target;
    target = n_start + nframes;
    go = 1'b1;
    for (int k = 0; k < 400 && n_start < target; k++) begin
      @(negedge clk);
      #1;
    end
    go = 1'b0;
    chk({name, " encStart count"}, n_start, target);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400 && (q_rand.size() + q_raw.size()) != 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk({name, " expected bytes left"}, 32'(q_rand.size() + q_raw.size()), 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin : main
    rand_tab = '{8'hFF, 8'h48, 8'h0E, 8'hC0, 8'h9A, 8'h0D, 8'h70, 8'hBC,
                 8'h8E, 8'h2C, 8'h93, 8'hAD, 8'hA7, 8'hB7, 8'h46, 8'hCE};
    asm_w = 32'h1ACFFC1D;

    #2 nGrst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", 32'({bus.outDat, bus.outValid, bus.outSof, bus.outEof, bus.encStart, busy, ovf_err}), 32'd0);
    chk("reset fifo empty", 32'(u_dut.u_fifo.empty), 32'd1);
    nGrst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle after reset", 32'({busy, bus.outValid, bus.encStart}), 32'd0);

    // All-zero codeword: bare randomizer sequence; raw framer must give exactly 20 valids
    cw.d = '0;
    cw.stall_at = -1;
    cw.stall_len = 0;
    cw_q.push_back(cw);
    expect_frame(cw);
    v0 = n_raw_vld;
    run_frames(1, "zero");
    wait_drain("zero");
    chk("raw valid pulses per frame", 32'(n_raw_vld - v0), 32'd20);
    chk("idle after frame", 32'(busy), 32'd0);

    // Stall of 5 cycles before symbol 6: holes must not advance the randomizer
    for (int i = 0; i < NN; i++) cw.d[i] = 8'(8'h10 + i);
    cw.stall_at = 6;
    cw.stall_len = 5;
    cw_q.push_back(cw);
    expect_frame(cw);
    run_frames(1, "stall");
    wait_drain("stall");

    // Overflow: 8 pushes fill the FIFO, the 9th overflows; sticky until rst with clkEn=1
    ovf_req_n = 8;
    ovf_req++;
    repeat (14) @(negedge clk);
    #1;
    chk("no ovf at exactly full", 32'(ovf_err), 32'd0);
    chk("fifo full after 8 pushes", 32'(u_dut.u_fifo.full), 32'd1);
    ovf_req_n = 1;
    ovf_req++;
    repeat (5) @(negedge clk);
    #1;
    chk("ovfErr after 9th push", 32'({ovf_err, ovf_err_raw}), 32'h3);
    repeat (5) @(negedge clk);
    #1;
    chk("ovfErr sticky", 32'(ovf_err), 32'd1);
    clkEn = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst ignored while clkEn=0", 32'(ovf_err), 32'd1);
    clkEn = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("ovfErr cleared by rst", 32'({ovf_err, ovf_err_raw}), 32'd0);
    chk("fifo flushed by rst", 32'(u_dut.u_fifo.empty), 32'd1);

    // Asynchronous reset at data byte 7, then a clean frame
    for (int i = 0; i < NN; i++) cw.d[i] = 8'(8'hA0 ^ i);
    cw.stall_at = -1;
    cw.stall_len = 0;
    cw_q.push_back(cw);
    expect_frame(cw);
    base = n_seen;
    run_frames(1, "rstmid");
    for (t = 0; t < 200 && n_seen < base + 11; t++) begin
      @(negedge clk);
      #1;
    end
    chk("rstmid reached data byte 7", 32'(n_seen - base), 32'd11);
    abort = 1'b1;
    nGrst = 1'b0;
    q_rand.delete();
    q_raw.delete();
    #1;
    chk("rstmid outputs zero", 32'({bus.outDat, bus.outValid, bus.outSof, bus.outEof, bus.encStart, busy}), 32'd0);
    chk("rstmid raw outputs zero", 32'({bus_raw.outDat, bus_raw.outValid, bus_raw.outEof, busy_raw}), 32'd0);
    repeat (4) @(negedge clk);
    nGrst = 1'b1;
    abort = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid busy after release", 32'(busy), 32'd0);
    chk("rstmid fifo empty after release", 32'(u_dut.u_fifo.empty), 32'd1);
    cw.d = '0;
    cw_q.push_back(cw);
    expect_frame(cw);
    run_frames(1, "after rst");
    wait_drain("after rst");

    // Back-to-back frames with go held: each reseeds the randomizer
    for (int i = 0; i < NN; i++) begin
      cw.d[i] = 8'(i * 17);
      cw2.d[i] = ~8'(i);
    end
    cw.stall_at = -1;
    cw.stall_len = 0;
    cw2.stall_at = -1;
    cw2.stall_len = 0;
    cw_q.push_back(cw);
    cw_q.push_back(cw2);
    expect_frame(cw);
    expect_frame(cw2);
    run_frames(2, "b2b");
    wait_drain("b2b");
    chk("codewords consumed", 32'(cw_q.size()), 32'd0);
    chk("idle at end", 32'({busy, busy_raw}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tm_cadu_framer.md
Name: tm_cadu_framer

Overview:
- Downstream neighbour of the RS encoder in the TM chain.
- Drives the encoder's start, buffers its output symbols, and emits each channel-access unit as a byte stream: the 32-bit ASM, then NN randomized codeword bytes.
- Randomizing uses the CCSDS pseudo-randomizer, h(x)=x^8+x^7+x^5+x^3+1, seeded to all ones at every frame.
- The byte stream feeds the TM serializer/modulator interface.

Parameters:
- NN, 255, codeword length in 8-bit symbols; range 16..255.
- ASM, 32'h1ACFFC1D, attached sync marker, sent MSB byte first.
- RAND_EN, 1, 1 = randomize codeword bytes; 0 = pass them through.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8.

Ports:
- clk  in  1  system clock.
- nGrst  in  1  asynchronous active-low reset.
- rst  in  1  synchronous reset; acts only when clkEn=1.
- clkEn  in  1  global clock enable; when 0, all state holds.
- go  in  1  frame request level; sampled in IDLE.
- encRfs  in  1  encoder ready-for-start.
- encStart  out  1  one-cycle start pulse to the encoder.
- rsIn  in  8  encoder output symbol.
- rsRdy  in  1  rsIn valid, one symbol per clkEn cycle.
- outDat  out  8  output byte.
- outValid  out  1  outDat valid.
- outSof  out  1  asserted with the first ASM byte.
- outEof  out  1  asserted with the last codeword byte.
- busy  out  1  high in every state except IDLE.
- ovfErr  out  1  sticky; set on FIFO overflow.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low (nGrst); rst is the synchronous reset. All state changes only when clkEn=1.
- Reset values: all outputs 0; FSM=IDLE; FIFO empty; LFSR=8'hFF; all counters 0.
- A rst taken mid-frame aborts the frame. No further output bytes are produced, and the FIFO is flushed.
- FSM states: IDLE, STRT, ASMB, DATA.
- IDLE: when go=1 and encRfs=1, go to STRT. Otherwise stay.
- STRT (one cycle):
  - encStart=1.
  - LFSR reloads to 8'hFF.
  - asmCnt and datCnt clear to 0.
  - Next state is ASMB.
- ASMB: outputs ASM bytes [31:24], [23:16], [15:8], [7:0] on 4 consecutive cycles, with outValid=1. outSof=1 on the first byte only. After byte 3, go to DATA.
- DATA:
  - Each cycle with the FIFO non-empty: pop one byte, outValid=1, outDat = fifo byte XOR LFSR byte (or raw when RAND_EN=0). The LFSR then advances 8 bit-steps.
  - FIFO empty: outValid=0. Holes in the stream are allowed and the frame is not aborted.
  - On pop number NN: outEof=1, then go to IDLE.
  - go and encRfs are ignored in this state.
- Randomizer sequence: the first 8 bytes after reload are FF 48 0E C0 9A 0D 70 BC. Each byte takes its MSB from the first LFSR bit out.
- Output registers: outDat, outValid, outSof and outEof are all registered, so one output register stage follows the FSM/FIFO decision.
- Push side:
  - Every clkEn cycle with rsRdy=1 writes rsIn into the FIFO, in any state.
  - Push while full: the byte is dropped and ovfErr is set (sticky until rst or nGrst).
  - A push and a pop in the same cycle, when full, is legal and not an overflow.
- Throughput: the encoder starts producing symbols while ASM is being sent. Peak FIFO occupancy is therefore at most 4 + encoder latency, which is at most 8.
- Frame spacing: back-to-back frames are separated by at least the IDLE and STRT cycles plus the encoder's encRfs recovery.

Decomposition:
- Shared tm_pkg holds:
  - ASM default;
  - the randomizer polynomial and seed constants;
  - the FSM state encoding;
  - a function lfsr_byte_next(state) returning the {byte, next_state} pair.
- One sub-module, tm_cadu_fifo: synchronous FIFO with parameters FIFO_AW and width 8. Its ports are push, pop, din, dout, full, empty, and it has the same reset scheme as this block.

Test Plan:
- All-zero codeword, NN=16, RAND_EN=1:
  - Stimulus: go=1 held; encoder model returns 16 zeros 3 cycles after encStart.
  - Required response: outDat = 1A CF FC 1D FF 48 0E C0 9A 0D 70 BC ...; outSof on 1A; outEof on byte 20.
- Same stimulus with RAND_EN=0: the codeword bytes appear unchanged after the ASM, and exactly 20 outValid pulses are counted.
- Stall:
  - Stimulus: encoder withholds rsRdy for 5 cycles mid-codeword.
  - Required response: outValid drops for those cycles, no bytes are lost, the LFSR does not advance during the holes, and outEof arrives on the 16th data byte.
- Overflow: force 9 pushes with no pops (hold the FSM in ASMB by gating clkEn on the pop side through the model) -> ovfErr=1; it stays 1 until rst.
- Reset mid-DATA:
  - Stimulus: pulse nGrst low at data byte 7.
  - Required response: all outputs are 0 immediately. After release the FIFO is empty and busy=0, and the next frame begins with FF at its first data byte.
- Back-to-back frames with go held high: two complete frames, each with its own outSof and outEof, and the LFSR reseeded for each frame.
